i2c_tmp101_responder: RTL

//  I2C slave that emulates a TMP101 temperature sensor at address {4'b1001,ChipSelect}.

---
 rtl/i2c_tmp101_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_tmp101_responder.sv
// I2C slave emulating a TMP101 temperature sensor: 2-byte temperature reads,
// 1-byte pointer writes, open-drain SDA, never stretches SCL.
`timescale 1ns/1ps
module i2c_tmp101_responder #(
  parameter logic [3:0] DeviceID   = 4'b1001,
  parameter int         SyncStages = 2
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [2:0]  ChipSelect,
  input  logic [15:0] Temperature,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [7:0]  Pointer,
  output logic        Busy,
  output logic        ReadDone
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, RX, ACK_W, TX, MACK} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  pointer_n;
  logic [15:0] temp_hold;
  logic        oe, oe_n;
  logic        busy_n, done_n;
  logic        rw, rw_n;
  logic        sel, sel_n;
  logic        load_temp;

  // Extra top flop holds the previous synchronised value for edge detection.
  logic [SyncStages:0] scl_sync, sda_sync;
  logic scl_s, scl_q, sda_s, sda_q;
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] next_byte;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-1:0], SCL};
      sda_sync <= {sda_sync[SyncStages-1:0], SDA};
    end
  end

  assign scl_s    = scl_sync[SyncStages-1];
  assign scl_q    = scl_sync[SyncStages];
  assign sda_s    = sda_sync[SyncStages-1];
  assign sda_q    = sda_sync[SyncStages];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

  // sel marks the byte just sent (0 = MSB), so the next one is the other half.
  assign next_byte = sel ? temp_hold[15:8] : temp_hold[7:0];

  assign SDA = oe ? 1'b0 : 1'bz;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift;
    oe_n      = oe;
    pointer_n = Pointer;
    busy_n    = Busy;
    done_n    = 1'b0;
    rw_n      = rw;
    sel_n     = sel;
    load_temp = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      shift_n = 8'h00;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (shift[6:0] != {DeviceID, ChipSelect}) begin
                state_n = IDLE;
                cnt_n   = 4'd0;
              end else begin
                rw_n = sda_s;
              end
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = ACK_A;
            oe_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end
        ACK_A: begin
          if (scl_fall) begin
            cnt_n = 4'd0;
            if (rw) begin
              state_n   = TX;
              load_temp = 1'b1;
              shift_n   = Temperature[15:8];
              oe_n      = ~Temperature[15];
              sel_n     = 1'b0;
            end else begin
              state_n = RX;
              oe_n    = 1'b0;
            end
          end
        end
        RX: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) pointer_n = {shift[6:0], sda_s};
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = ACK_W;
            oe_n    = 1'b1;
          end
        end
        ACK_W: begin
          if (scl_fall) begin
            state_n = RX;
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
          end
        end
        TX: begin
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              state_n = MACK;
              oe_n    = 1'b0;
              cnt_n   = 4'd0;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              oe_n    = ~shift[6];
              cnt_n   = cnt + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_n = IDLE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              cnt_n = 4'd8;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = TX;
            cnt_n   = 4'd0;
            sel_n   = ~sel;
            shift_n = next_byte;
            oe_n    = ~next_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shift    <= 8'h00;
      oe       <= 1'b0;
      Pointer  <= 8'h00;
      Busy     <= 1'b0;
      ReadDone <= 1'b0;
      rw       <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      oe       <= oe_n;
      Pointer  <= pointer_n;
      Busy     <= busy_n;
      ReadDone <= done_n;
      rw       <= rw_n;
      sel      <= sel_n;
    end
  end

  // Snapshot taken at the address ACK so a read never sees a torn value.
  always_ff @(posedge clock) begin
    if (load_temp) temp_hold <= Temperature;
  end

endmodule
